// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with flush/bubble/hold control, a multi-cycle side-state return path and event counters.
// One-cycle latency; stall[STAGE]/stall[STAGE+1] choose hold or bubble, and flush overrides every stall pattern.
module pipe_stage_reg #(
    parameter int                DATA_W     = 200,
    parameter int                SIDE_W     = 66,
    parameter int                STALL_W    = 6,
    parameter int                STAGE      = 3,
    parameter logic [DATA_W-1:0] NOP_DATA   = '0,
    parameter bit                FLUSH_SIDE = 1'b1,
    parameter int                CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SIDE_W-1:0]  side_i,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [SIDE_W-1:0]  side_o,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic [CNT_W-1:0]   hold_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic               r_valid;
    logic [DATA_W-1:0]  r_data;
    logic [SIDE_W-1:0]  r_side;
    logic [CNT_W-1:0]   r_bubble_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    logic [CNT_W-1:0]   r_hold_cnt;

    logic w_stall_here;
    logic w_stall_next;
    logic w_bubble;
    logic w_advance;
    logic w_hold;
    logic w_flush_kill;
    logic w_unused_stall;

    assign w_stall_here = stall[STAGE];
    assign w_stall_next = stall[STAGE+1];

    // Only this stage's bit and its downstream neighbour matter; the rest are ignored.
    assign w_unused_stall = ^stall;

    assign w_bubble     = !flush &&  w_stall_here && !w_stall_next;
    assign w_advance    = !flush && !w_stall_here;
    assign w_hold       = !flush &&  w_stall_here &&  w_stall_next;
    assign w_flush_kill =  flush &&  r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= NOP_DATA;
            r_side  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_data  <= NOP_DATA;
            if (FLUSH_SIDE) begin
                r_side <= '0;
            end
        end else if (w_bubble) begin
            r_valid <= 1'b0;
            r_data  <= NOP_DATA;
            r_side  <= side_i;
        end else if (w_advance) begin
            r_valid <= in_valid;
            r_data  <= in_data;
            r_side  <= '0;
        end else begin
            // Hold keeps the payload but still returns the stalled stage's side state.
            r_side  <= side_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
            r_hold_cnt   <= '0;
        end else begin
            if (w_bubble && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
            if (w_flush_kill && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
            if (w_hold && (r_hold_cnt != CNT_MAX)) begin
                r_hold_cnt <= r_hold_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign side_o     = r_side;
    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign hold_cnt   = r_hold_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed plus random bench for pipe_stage_reg: three instances (default, side held on flush, 2-bit counters)
// share one stimulus stream and are checked against a queued reference model.
module tb_pipe_stage_reg;

    localparam int DW = 200;
    localparam int SW = 66;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] data;
        logic [SW-1:0] side;
        logic [15:0]   bc;
        logic [15:0]   fc;
        logic [15:0]   hc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [SW-1:0] side_i;

    logic          a_valid, b_valid, c_valid;
    logic [DW-1:0] a_data, b_data, c_data;
    logic [SW-1:0] a_side, b_side, c_side;
    logic [15:0]   a_bc, a_fc, a_hc, b_bc, b_fc, b_hc;
    logic [1:0]    c_bc, c_fc, c_hc;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t m[3];
    bit   fs[3]   = '{1'b1, 1'b0, 1'b1};
    int   cmax[3] = '{65535, 65535, 3};
    logic [SW-1:0] last_side;
    logic [15:0]   bc_before;

    always #5 clk = ~clk;

    pipe_stage_reg u_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .side_i(side_i), .out_valid(a_valid), .out_data(a_data),
        .side_o(a_side), .bubble_cnt(a_bc), .flush_cnt(a_fc), .hold_cnt(a_hc));

    pipe_stage_reg #(.FLUSH_SIDE(1'b0)) u_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .side_i(side_i), .out_valid(b_valid), .out_data(b_data),
        .side_o(b_side), .bubble_cnt(b_bc), .flush_cnt(b_fc), .hold_cnt(b_hc));

    pipe_stage_reg #(.CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .side_i(side_i), .out_valid(c_valid), .out_data(c_data),
        .side_o(c_side), .bubble_cnt(c_bc), .flush_cnt(c_fc), .hold_cnt(c_hc));

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m[i] = '0;
    endtask

    function automatic logic [15:0] inc(input logic [15:0] v, input int mx);
        return (int'(v) < mx) ? v + 16'd1 : v;
    endfunction

    task automatic cmp_one(input string tag, input exp_t e, input logic v, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input logic [15:0] bc, input logic [15:0] fc,
                           input logic [15:0] hc);
        chk({tag, ".valid"}, 256'(v), 256'(e.valid));
        chk({tag, ".data"},  256'(d), 256'(e.data));
        chk({tag, ".side"},  256'(s), 256'(e.side));
        chk({tag, ".bcnt"},  256'(bc), 256'(e.bc));
        chk({tag, ".fcnt"},  256'(fc), 256'(e.fc));
        chk({tag, ".hcnt"},  256'(hc), 256'(e.hc));
    endtask

    // Drive one cycle of stimulus, push the model's expectation, then compare after the edge.
    task automatic step(input logic [5:0] st, input logic fl, input logic iv,
                        input logic [DW-1:0] id, input logic [SW-1:0] si);
        exp_t e;
        stall = st; flush = fl; in_valid = iv; in_data = id; side_i = si;
        for (int i = 0; i < 3; i++) begin
            if (fl) begin
                if (m[i].valid) m[i].fc = inc(m[i].fc, cmax[i]);
                m[i].valid = 1'b0;
                m[i].data  = '0;
                if (fs[i]) m[i].side = '0;
            end else if (st[3] && !st[4]) begin
                m[i].bc    = inc(m[i].bc, cmax[i]);
                m[i].valid = 1'b0;
                m[i].data  = '0;
                m[i].side  = si;
            end else if (!st[3]) begin
                m[i].valid = iv;
                m[i].data  = id;
                m[i].side  = '0;
            end else begin
                m[i].hc   = inc(m[i].hc, cmax[i]);
                m[i].side = si;
            end
            q.push_back(m[i]);
        end
        @(posedge clk);
        #1;
        e = q.pop_front(); cmp_one("a", e, a_valid, a_data, a_side, a_bc, a_fc, a_hc);
        e = q.pop_front(); cmp_one("b", e, b_valid, b_data, b_side, b_bc, b_fc, b_hc);
        e = q.pop_front(); cmp_one("c", e, c_valid, c_data, c_side, {14'd0, c_bc}, {14'd0, c_fc}, {14'd0, c_hc});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".a_valid"}, 256'(a_valid), 256'(0));
        chk({tag, ".a_data"},  256'(a_data),  256'(0));
        chk({tag, ".a_side"},  256'(a_side),  256'(0));
        chk({tag, ".a_cnts"},  256'({a_bc, a_fc, a_hc}), 256'(0));
        chk({tag, ".b_side"},  256'(b_side),  256'(0));
        chk({tag, ".c_cnts"},  256'({c_bc, c_fc, c_hc}), 256'(0));
    endtask

    initial begin
        logic [223:0] rd;
        logic [95:0]  rs;
        logic [5:0]   rst_v;

        rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0; side_i = '0;
        model_reset();
        #1;
        chk_all_zero("reset_state");
        @(posedge clk); @(posedge clk);
        #1;
        rst = 1'b0;

        // Advance
        step(6'b000000, 1'b0, 1'b1, 200'hA5, 66'h0);
        chk("adv_valid", 256'(a_valid), 256'(1));
        chk("adv_data",  256'(a_data),  256'(200'hA5));
        chk("adv_side",  256'(a_side),  256'(0));

        // Bubble with in_valid low
        step(6'b001000, 1'b0, 1'b0, 200'h77, 66'h3_0000_0001_0000_0002);
        chk("bub_valid", 256'(a_valid), 256'(0));
        chk("bub_side",  256'(a_side),  256'(66'h3_0000_0001_0000_0002));
        chk("bub_cnt",   256'(a_bc),    256'(1));

        // Hold for three cycles
        step(6'b000000, 1'b0, 1'b1, 200'h5A, 66'h0);
        for (int k = 1; k <= 3; k++) begin
            step(6'b011000, 1'b0, 1'b0, 200'hFF, 66'(k * 66'h1_0000_0011));
            chk("hold_side_track", 256'(a_side), 256'(k * 66'h1_0000_0011));
        end
        chk("hold_data", 256'(a_data), 256'(200'h5A));
        chk("hold_cnt",  256'(a_hc),   256'(3));
        last_side = b_side;
        bc_before = a_bc;

        // Flush over a bubble pattern, valid entry present
        step(6'b001000, 1'b1, 1'b1, 200'h99, 66'h2_AAAA);
        chk("flush_valid", 256'(a_valid), 256'(0));
        chk("flush_cnt",   256'(a_fc),    256'(1));
        chk("flush_bcnt",  256'(a_bc),    256'(bc_before));
        chk("flush_hold_side", 256'(b_side), 256'(last_side));
        chk("flush_clr_side",  256'(a_side), 256'(0));

        // Flush with no valid entry must not count
        step(6'b011000, 1'b1, 1'b1, 200'h1, 66'h1);
        chk("flush_idle_cnt", 256'(a_fc), 256'(1));

        // Unrelated stall bits
        step(6'b100111, 1'b0, 1'b1, 200'hC3, 66'h5);
        step(6'b101011, 1'b0, 1'b1, 200'hC4, 66'h6);
        step(6'b111111, 1'b0, 1'b1, 200'hC5, 66'h7);

        // Saturation of the 2-bit counters
        for (int k = 0; k < 5; k++) step(6'b001000, 1'b0, 1'b0, '0, 66'(k));
        chk("sat_bcnt", 256'(c_bc), 256'(3));

        // Async reset between edges while valid and mid-hold
        step(6'b000000, 1'b0, 1'b1, 200'hBEEF, 66'h0);
        step(6'b011000, 1'b0, 1'b0, 200'h0, 66'h3_1234_5678);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        #1;
        rst = 1'b0;
        step(6'b011000, 1'b0, 1'b1, 200'h42, 66'h1_0F0F);
        step(6'b000000, 1'b0, 1'b1, 200'h43, 66'h0);

        // Random mix
        for (int n = 0; n < 60; n++) begin
            rd    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            rs    = {$urandom, $urandom, $urandom};
            rst_v = 6'($urandom);
            step(rst_v, ($urandom_range(0, 7) == 0), 1'($urandom), rd[DW-1:0], rs[SW-1:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 200, SHALL set the payload width carried from the upstream stage to the downstream stage.
REQ-002 Parameter SIDE_W, default 66, SHALL set the width of the multi-cycle side-state channel (default: 64-bit hilo plus 2-bit cycle count).
REQ-003 Parameter STALL_W, default 6, SHALL set the width of the stall vector.
REQ-004 Parameter STAGE, default 3, SHALL set this register's index into the stall vector; legal range 0..STALL_W-2.
REQ-005 Parameter NOP_DATA, default all-zero DATA_W, SHALL set the payload value driven on reset, flush and bubble.
REQ-006 Parameter FLUSH_SIDE, default 1, SHALL select whether flush clears the side channel (1) or holds it (0).
REQ-007 Parameter CNT_W, default 16, SHALL set the width of each event counter.
REQ-008 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-009 clk  input  1  rising-edge clock.
REQ-010 rst  input  1  asynchronous active-high reset.
REQ-011 stall  input  STALL_W  per-stage stop vector; bit=1 means the stage stops.
REQ-012 flush  input  1  exception flush request.
REQ-013 in_valid  input  1  upstream payload is a real instruction.
REQ-014 in_data  input  DATA_W  upstream payload.
REQ-015 side_i  input  SIDE_W  multi-cycle state from upstream, valid while upstream is stalled.
REQ-016 out_valid  output  1  registered valid.
REQ-017 out_data  output  DATA_W  registered payload.
REQ-018 side_o  output  SIDE_W  registered side state returned to upstream.
REQ-019 bubble_cnt  output  CNT_W  count of bubbles inserted.
REQ-020 flush_cnt  output  CNT_W  count of flush cycles that killed a valid entry.
REQ-021 hold_cnt  output  CNT_W  count of cycles the stage held its contents.

Function
REQ-022 Per rising clk edge, exactly one action SHALL apply, priority: flush > bubble > advance > hold.
REQ-023 Bubble condition SHALL be stall[STAGE]=1 and stall[STAGE+1]=0.
REQ-024 Advance condition SHALL be stall[STAGE]=0.
REQ-025 Hold condition SHALL be stall[STAGE]=1 and stall[STAGE+1]=1.
REQ-026 Flush SHALL set out_valid=0 and out_data=NOP_DATA; side_o SHALL become 0 if FLUSH_SIDE=1, otherwise keep its value.
REQ-027 Bubble SHALL set out_valid=0, out_data=NOP_DATA, and side_o=side_i.
REQ-028 Advance SHALL set out_valid=in_valid, out_data=in_data, and side_o=0.
REQ-029 Hold SHALL keep out_valid and out_data unchanged and set side_o=side_i.
REQ-030 All outputs SHALL be registered with latency 1 cycle; no combinational input-to-output path SHALL exist.
REQ-031 bubble_cnt SHALL increment on every bubble edge, including when in_valid=0.
REQ-032 flush_cnt SHALL increment on a flush edge only when out_valid=1 before that edge.
REQ-033 hold_cnt SHALL increment on every hold edge.
REQ-034 Each counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-035 Flush coincident with any stall pattern SHALL follow REQ-026 only.
REQ-036 stall bits other than STAGE and STAGE+1 SHALL have no effect.

Reset
REQ-037 While rst=1, the block SHALL immediately force, without waiting for clk: out_valid=0, out_data=NOP_DATA, side_o=0, and all counters=0.
REQ-038 Reset asserted mid-hold or mid-bubble SHALL discard captured side state.
REQ-039 After rst deasserts, the first clk edge SHALL apply REQ-022 normally.

Verification
REQ-040 Advance: stall=0, in_valid=1, in_data=0xA5 -> next cycle out_valid=1, out_data=0xA5, side_o=0.
REQ-041 Bubble: stall=6'b001000, side_i=0x3_0000_0001_0000_0002 -> out_valid=0, out_data=NOP_DATA, side_o=side_i, bubble_cnt=1.
REQ-042 Hold: load 0x5A, then stall=6'b011000 for 3 cycles -> out_data stays 0x5A, hold_cnt=3, side_o tracks side_i each cycle.
REQ-043 Flush priority: valid entry held, then flush=1 with stall=6'b001000 -> out_valid=0, flush_cnt=1, bubble_cnt unchanged; with FLUSH_SIDE=0, side_o retains its prior value.
REQ-044 Async reset: pulse rst between clk edges while out_valid=1 -> outputs zero before the next edge; counters=0.
REQ-045 Saturation: CNT_W=2, 5 bubble cycles -> bubble_cnt=3.
